// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and lane helpers for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE0 = 3'd1,
    S_WAIT0  = 3'd2,
    S_ISSUE1 = 3'd3,
    S_WAIT1  = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  // Byte enables across two consecutive aligned words: the low XLEN/8 bits
  // belong to the first beat, the next XLEN/8 bits to the second beat.
  function automatic logic [15:0] be_mask(input size_e size, input logic [2:0] off,
                                          input int unsigned xlen);
    logic [15:0] m;
    logic [15:0] keep;
    m    = ((16'd1 << (5'd1 << size)) - 16'd1) << off;
    keep = 16'((32'd1 << (xlen / 4)) - 32'd1);
    return m & keep;
  endfunction

  // Sign or zero extension of a right-justified value of the given size.
  function automatic logic [63:0] extend(input logic [63:0] data, input size_e size,
                                         input logic uns);
    case (size)
      SZ_B:    return uns ? {56'd0, data[7:0]}  : {{56{data[7]}}, data[7:0]};
      SZ_H:    return uns ? {48'd0, data[15:0]} : {{48{data[15]}}, data[15:0]};
      SZ_W:    return uns ? {32'd0, data[31:0]} : {{32{data[31]}}, data[31:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane shift and load extract/extend datapath
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]              wdata_i,
  input  logic [$clog2(XLEN/8)-1:0]    off_i,
  input  size_e                        size_i,
  input  logic                         uns_i,
  input  logic [2*XLEN-1:0]            rbuf_i,
  output logic [XLEN-1:0]              wdata0_o,
  output logic [XLEN-1:0]              wdata1_o,
  output logic [XLEN-1:0]              rdata_o
);

  logic [2*XLEN-1:0] wide;

  // Store data spread over two words; the upper word is the spill-over beat.
  // Load data is pulled down from the two-word buffer, then extended.
  always_comb begin
    wide     = {{XLEN{1'b0}}, wdata_i} << {off_i, 3'b000};
    wdata0_o = wide[XLEN-1:0];
    wdata1_o = wide[2*XLEN-1:XLEN];
    rdata_o  = XLEN'(extend(64'(XLEN'(rbuf_i >> {off_i, 3'b000})), size_i, uns_i));
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit with valid/ready memory beats and misaligned split
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned ADDR_W           = 32,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [ADDR_W-1:0]    req_addr_i,
  input  logic [XLEN-1:0]      req_wdata_i,
  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [XLEN-1:0]      mem_wdata_o,
  output logic [XLEN/8-1:0]    mem_be_o,
  input  logic                 mem_rvalid_i,
  input  logic [XLEN-1:0]      mem_rdata_i,
  output logic                 resp_valid_o,
  output logic                 resp_err_o,
  output logic [XLEN-1:0]      resp_rdata_o,
  output logic                 stall_o
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  state_e              state_q, state_d;
  logic [2*XLEN-1:0]   rbuf_q, rbuf_d;
  logic                we_q, uns_q, err_q, cross_q;
  size_e               size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]     wdata_q;

  logic                accept;
  logic [OFF_W-1:0]    req_off;
  logic [3:0]          req_span;
  logic                req_cross, req_illegal, req_err;

  logic [OFF_W-1:0]    off_q;
  logic [ADDR_W-1:0]   base_addr;
  logic [15:0]         mask;
  logic [XLEN-1:0]     wdata0, wdata1, load_data;

  assign req_ready_o = (state_q == S_IDLE);
  assign stall_o     = !req_ready_o | req_valid_i;
  assign accept      = req_valid_i & req_ready_o;

  // Classify the incoming request: lane offset, line crossing and error cases.
  always_comb begin
    req_off     = req_addr_i[OFF_W-1:0];
    req_span    = 4'(req_off) + (4'd1 << req_size_i);
    req_cross   = req_span > 4'(NB);
    req_illegal = (XLEN == 32) && (req_size_i == 2'd3);
    req_err     = req_illegal | (req_cross & !SPLIT_MISALIGNED);
  end

  // Next-state logic and load-buffer capture for the access sequence.
  always_comb begin
    state_d = state_q;
    rbuf_d  = rbuf_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rbuf_d  = '0;
          state_d = req_err ? S_RESP : S_ISSUE0;
        end
      end
      S_ISSUE0: begin
        if (mem_ready_i) begin
          if (!we_q)        state_d = S_WAIT0;
          else if (cross_q) state_d = S_ISSUE1;
          else              state_d = S_RESP;
        end
      end
      S_WAIT0: begin
        if (mem_rvalid_i) begin
          rbuf_d[XLEN-1:0] = mem_rdata_i;
          state_d          = cross_q ? S_ISSUE1 : S_RESP;
        end
      end
      S_ISSUE1: begin
        if (mem_ready_i) state_d = we_q ? S_RESP : S_WAIT1;
      end
      S_WAIT1: begin
        if (mem_rvalid_i) begin
          rbuf_d[2*XLEN-1:XLEN] = mem_rdata_i;
          state_d               = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and load buffer; reset drops any beat in flight immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      rbuf_q  <= rbuf_d;
    end
  end

  // Request fields are held for the whole access once accepted.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      cross_q <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we_i;
      uns_q   <= req_unsigned_i;
      err_q   <= req_err;
      cross_q <= req_cross;
      size_q  <= size_e'(req_size_i);
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
    end
  end

  assign off_q     = addr_q[OFF_W-1:0];
  assign base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mask      = be_mask(size_q, 3'(off_q), XLEN);

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .wdata_i  (wdata_q),
    .off_i    (off_q),
    .size_i   (size_q),
    .uns_i    (uns_q),
    .rbuf_i   (rbuf_q),
    .wdata0_o (wdata0),
    .wdata1_o (wdata1),
    .rdata_o  (load_data)
  );

  // Memory beat and response outputs decoded from the current state.
  always_comb begin
    mem_valid_o  = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_be_o     = '0;
    resp_valid_o = 1'b0;
    resp_err_o   = 1'b0;
    resp_rdata_o = '0;
    case (state_q)
      S_ISSUE0: begin
        mem_valid_o = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = base_addr;
        mem_wdata_o = wdata0;
        mem_be_o    = NB'(mask);
      end
      S_ISSUE1: begin
        mem_valid_o = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = base_addr + ADDR_W'(NB);
        mem_wdata_o = wdata1;
        mem_be_o    = NB'(mask >> NB);
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        resp_err_o   = err_q;
        resp_rdata_o = (err_q | we_q) ? '0 : load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for the load/store unit
module tb_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  // DUT a: XLEN=32, misaligned split enabled
  logic        a_req_valid = 0, a_req_ready, a_req_we = 0, a_req_unsigned = 0;
  logic [1:0]  a_req_size = 0;
  logic [31:0] a_req_addr = 0, a_req_wdata = 0;
  logic        a_mem_valid, a_mem_ready = 0, a_mem_we, a_mem_rvalid = 0;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata = 0, a_resp_rdata;
  logic [3:0]  a_mem_be;
  logic        a_resp_valid, a_resp_err, a_stall;

  // DUT b: XLEN=32, misaligned accesses are errors
  logic        b_req_valid = 0, b_req_ready, b_req_we = 0, b_req_unsigned = 0;
  logic [1:0]  b_req_size = 0;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0;
  logic        b_mem_valid, b_mem_ready = 0, b_mem_we, b_mem_rvalid = 0;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata = 0, b_resp_rdata;
  logic [3:0]  b_mem_be;
  logic        b_resp_valid, b_resp_err, b_stall;

  // DUT c: XLEN=64
  logic        c_req_valid = 0, c_req_ready, c_req_we = 0, c_req_unsigned = 0;
  logic [1:0]  c_req_size = 0;
  logic [31:0] c_req_addr = 0, c_mem_addr;
  logic [63:0] c_req_wdata = 0, c_mem_wdata, c_mem_rdata = 0, c_resp_rdata;
  logic        c_mem_valid, c_mem_ready = 0, c_mem_we, c_mem_rvalid = 0;
  logic [7:0]  c_mem_be;
  logic        c_resp_valid, c_resp_err, c_stall;

  lsu #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) u_a (
    .clk_i(clk), .reset_i(rst), .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
    .req_we_i(a_req_we), .req_size_i(a_req_size), .req_unsigned_i(a_req_unsigned),
    .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata), .mem_valid_o(a_mem_valid),
    .mem_ready_i(a_mem_ready), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
    .mem_wdata_o(a_mem_wdata), .mem_be_o(a_mem_be), .mem_rvalid_i(a_mem_rvalid),
    .mem_rdata_i(a_mem_rdata), .resp_valid_o(a_resp_valid), .resp_err_o(a_resp_err),
    .resp_rdata_o(a_resp_rdata), .stall_o(a_stall));

  lsu #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) u_b (
    .clk_i(clk), .reset_i(rst), .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
    .req_we_i(b_req_we), .req_size_i(b_req_size), .req_unsigned_i(b_req_unsigned),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .mem_valid_o(b_mem_valid),
    .mem_ready_i(b_mem_ready), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
    .mem_wdata_o(b_mem_wdata), .mem_be_o(b_mem_be), .mem_rvalid_i(b_mem_rvalid),
    .mem_rdata_i(b_mem_rdata), .resp_valid_o(b_resp_valid), .resp_err_o(b_resp_err),
    .resp_rdata_o(b_resp_rdata), .stall_o(b_stall));

  lsu #(.XLEN(64), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) u_c (
    .clk_i(clk), .reset_i(rst), .req_valid_i(c_req_valid), .req_ready_o(c_req_ready),
    .req_we_i(c_req_we), .req_size_i(c_req_size), .req_unsigned_i(c_req_unsigned),
    .req_addr_i(c_req_addr), .req_wdata_i(c_req_wdata), .mem_valid_o(c_mem_valid),
    .mem_ready_i(c_mem_ready), .mem_we_o(c_mem_we), .mem_addr_o(c_mem_addr),
    .mem_wdata_o(c_mem_wdata), .mem_be_o(c_mem_be), .mem_rvalid_i(c_mem_rvalid),
    .mem_rdata_i(c_mem_rdata), .resp_valid_o(c_resp_valid), .resp_err_o(c_resp_err),
    .resp_rdata_o(c_resp_rdata), .stall_o(c_stall));

  // 10-unit clock
  always #5 clk = ~clk;

  // Presents one request to DUT a for a single cycle; returns at the cycle-1 negedge.
  task automatic a_issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    a_req_valid = 1'b1; a_req_we = we; a_req_size = size; a_req_unsigned = uns;
    a_req_addr = addr; a_req_wdata = wdata;
    @(negedge clk);
    a_req_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_total++; if (a_req_ready !== 1'b1) $display("FAIL rst_req_ready got %0h want 1", a_req_ready); else n_pass++;
    n_total++; if (a_mem_valid !== 1'b0) $display("FAIL rst_mem_valid got %0h want 0", a_mem_valid); else n_pass++;
    n_total++; if (a_resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %0h want 0", a_resp_valid); else n_pass++;
    n_total++; if (a_resp_rdata !== 32'h0) $display("FAIL rst_resp_rdata got %0h want 0", a_resp_rdata); else n_pass++;
    n_total++; if (a_stall !== 1'b0) $display("FAIL rst_stall got %0h want 0", a_stall); else n_pass++;
    n_total++; if (c_mem_be !== 8'h00) $display("FAIL rst_c_mem_be got %0h want 0", c_mem_be); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (a_req_ready !== 1'b1) $display("FAIL post_rst_req_ready got %0h want 1", a_req_ready); else n_pass++;
  endtask

  task automatic test_load_byte;
    a_issue(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0);
    n_total++; if (a_mem_valid !== 1'b1) $display("FAIL lb_mem_valid got %0h want 1", a_mem_valid); else n_pass++;
    n_total++; if (a_mem_addr !== 32'h0000_1000) $display("FAIL lb_mem_addr got %0h want 1000", a_mem_addr); else n_pass++;
    n_total++; if (a_mem_be !== 4'b1000) $display("FAIL lb_mem_be got %0b want 1000", a_mem_be); else n_pass++;
    n_total++; if (a_mem_we !== 1'b0) $display("FAIL lb_mem_we got %0h want 0", a_mem_we); else n_pass++;
    n_total++; if (a_stall !== 1'b1) $display("FAIL lb_stall got %0h want 1", a_stall); else n_pass++;
    a_mem_ready = 1'b1;
    @(negedge clk);
    a_mem_ready = 1'b0;
    n_total++; if (a_resp_valid !== 1'b0) $display("FAIL lb_early_resp got %0h want 0", a_resp_valid); else n_pass++;
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'h80FF_FF00;
    @(negedge clk);
    a_mem_rvalid = 1'b0;
    n_total++; if (a_resp_valid !== 1'b1) $display("FAIL lb_resp_valid_c3 got %0h want 1", a_resp_valid); else n_pass++;
    n_total++; if (a_resp_rdata !== 32'hFFFF_FF80) $display("FAIL lb_resp_rdata got %0h want ffffff80", a_resp_rdata); else n_pass++;
    n_total++; if (a_resp_err !== 1'b0) $display("FAIL lb_resp_err got %0h want 0", a_resp_err); else n_pass++;
    @(negedge clk);
    n_total++; if (a_resp_valid !== 1'b0) $display("FAIL lb_resp_pulse got %0h want 0", a_resp_valid); else n_pass++;
  endtask

  task automatic test_store_half;
    a_issue(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
    n_total++; if (a_mem_be !== 4'b1100) $display("FAIL sh_mem_be got %0b want 1100", a_mem_be); else n_pass++;
    n_total++; if (a_mem_wdata !== 32'hBEEF_0000) $display("FAIL sh_mem_wdata got %0h want beef0000", a_mem_wdata); else n_pass++;
    n_total++; if (a_mem_addr !== 32'h0000_2000) $display("FAIL sh_mem_addr got %0h want 2000", a_mem_addr); else n_pass++;
    n_total++; if (a_mem_we !== 1'b1) $display("FAIL sh_mem_we got %0h want 1", a_mem_we); else n_pass++;
    a_mem_ready = 1'b1;
    @(negedge clk);
    a_mem_ready = 1'b0;
    n_total++; if (a_resp_valid !== 1'b1) $display("FAIL sh_resp_valid_c2 got %0h want 1", a_resp_valid); else n_pass++;
    n_total++; if (a_resp_rdata !== 32'h0) $display("FAIL sh_resp_rdata got %0h want 0", a_resp_rdata); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_split_load;
    a_issue(1'b0, 2'd2, 1'b0, 32'h0000_3003, 32'h0);
    n_total++; if (a_mem_addr !== 32'h0000_3000) $display("FAIL lw_split_addr0 got %0h want 3000", a_mem_addr); else n_pass++;
    n_total++; if (a_mem_be !== 4'b1000) $display("FAIL lw_split_be0 got %0b want 1000", a_mem_be); else n_pass++;
    a_mem_ready = 1'b1;
    @(negedge clk);
    a_mem_ready = 1'b0; a_mem_rvalid = 1'b1; a_mem_rdata = 32'h4433_2211;
    @(negedge clk);
    a_mem_rvalid = 1'b0;
    n_total++; if (a_mem_valid !== 1'b1) $display("FAIL lw_split_valid1 got %0h want 1", a_mem_valid); else n_pass++;
    n_total++; if (a_mem_addr !== 32'h0000_3004) $display("FAIL lw_split_addr1 got %0h want 3004", a_mem_addr); else n_pass++;
    n_total++; if (a_mem_be !== 4'b0111) $display("FAIL lw_split_be1 got %0b want 0111", a_mem_be); else n_pass++;
    a_mem_ready = 1'b1;
    @(negedge clk);
    a_mem_ready = 1'b0; a_mem_rvalid = 1'b1; a_mem_rdata = 32'h8877_6655;
    @(negedge clk);
    a_mem_rvalid = 1'b0;
    n_total++; if (a_resp_valid !== 1'b1) $display("FAIL lw_split_resp_valid got %0h want 1", a_resp_valid); else n_pass++;
    n_total++; if (a_resp_rdata !== 32'h7766_5544) $display("FAIL lw_split_rdata got %0h want 77665544", a_resp_rdata); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_stall_hold;
    a_issue(1'b0, 2'd1, 1'b0, 32'h0000_4002, 32'h0);
    for (int i = 0; i < 5; i++) begin
      n_total++; if (a_mem_valid !== 1'b1) $display("FAIL hold_valid[%0d] got %0h want 1", i, a_mem_valid); else n_pass++;
      n_total++; if (a_mem_addr !== 32'h0000_4000) $display("FAIL hold_addr[%0d] got %0h want 4000", i, a_mem_addr); else n_pass++;
      n_total++; if (a_mem_be !== 4'b1100) $display("FAIL hold_be[%0d] got %0b want 1100", i, a_mem_be); else n_pass++;
      n_total++; if (a_stall !== 1'b1) $display("FAIL hold_stall[%0d] got %0h want 1", i, a_stall); else n_pass++;
      @(negedge clk);
    end
    a_mem_ready = 1'b1;
    @(negedge clk);
    a_mem_ready = 1'b0; a_mem_rvalid = 1'b1; a_mem_rdata = 32'h9ABC_1234;
    @(negedge clk);
    a_mem_rvalid = 1'b0;
    n_total++; if (a_resp_rdata !== 32'hFFFF_9ABC) $display("FAIL lh_rdata got %0h want ffff9abc", a_resp_rdata); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    a_issue(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0);
    #2 rst = 1'b1;
    #1;
    n_total++; if (a_mem_valid !== 1'b0) $display("FAIL rstmid_issue_valid got %0h want 0", a_mem_valid); else n_pass++;
    n_total++; if (a_req_ready !== 1'b1) $display("FAIL rstmid_issue_ready got %0h want 1", a_req_ready); else n_pass++;
    #1 rst = 1'b0;
    @(negedge clk);
    a_issue(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0);
    a_mem_ready = 1'b1;
    @(negedge clk);
    a_mem_ready = 1'b0;
    n_total++; if (a_req_ready !== 1'b0) $display("FAIL rstmid_wait_busy got %0h want 0", a_req_ready); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (a_req_ready !== 1'b1) $display("FAIL rstmid_wait_ready got %0h want 1", a_req_ready); else n_pass++;
    #1 rst = 1'b0;
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++; if (a_resp_valid !== 1'b0) $display("FAIL stray_rvalid[%0d] got %0h want 0", i, a_resp_valid); else n_pass++;
    end
    a_mem_rvalid = 1'b0;
  endtask

  task automatic test_back_to_back;
    a_issue(1'b1, 2'd2, 1'b0, 32'h0000_2001, 32'hAABB_CCDD);
    n_total++; if (a_mem_be !== 4'b1110) $display("FAIL sw_split_be0 got %0b want 1110", a_mem_be); else n_pass++;
    n_total++; if (a_mem_wdata !== 32'hBBCC_DD00) $display("FAIL sw_split_wdata0 got %0h want bbccdd00", a_mem_wdata); else n_pass++;
    a_mem_ready = 1'b1;
    @(negedge clk);
    n_total++; if (a_mem_addr !== 32'h0000_2004) $display("FAIL sw_split_addr1 got %0h want 2004", a_mem_addr); else n_pass++;
    n_total++; if (a_mem_be !== 4'b0001) $display("FAIL sw_split_be1 got %0b want 0001", a_mem_be); else n_pass++;
    n_total++; if (a_mem_wdata !== 32'h0000_00AA) $display("FAIL sw_split_wdata1 got %0h want aa", a_mem_wdata); else n_pass++;
    @(negedge clk);
    a_mem_ready = 1'b0;
    n_total++; if (a_resp_valid !== 1'b1) $display("FAIL sw_split_resp_c3 got %0h want 1", a_resp_valid); else n_pass++;
    n_total++; if (a_req_ready !== 1'b0) $display("FAIL b2b_resp_ready got %0h want 0", a_req_ready); else n_pass++;
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_size = 2'd0; a_req_addr = 32'h0000_6003; a_req_wdata = 32'h0000_00C3;
    @(negedge clk);
    n_total++; if (a_req_ready !== 1'b1) $display("FAIL b2b_idle_ready got %0h want 1", a_req_ready); else n_pass++;
    n_total++; if (a_stall !== 1'b1) $display("FAIL b2b_stall got %0h want 1", a_stall); else n_pass++;
    @(negedge clk);
    a_req_valid = 1'b0;
    n_total++; if (a_mem_be !== 4'b1000) $display("FAIL b2b_sb_be got %0b want 1000", a_mem_be); else n_pass++;
    n_total++; if (a_mem_wdata !== 32'hC300_0000) $display("FAIL b2b_sb_wdata got %0h want c3000000", a_mem_wdata); else n_pass++;
    a_mem_ready = 1'b1;
    @(negedge clk);
    a_mem_ready = 1'b0;
    n_total++; if (a_resp_valid !== 1'b1) $display("FAIL b2b_sb_resp got %0h want 1", a_resp_valid); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_errors;
    a_issue(1'b0, 2'd3, 1'b0, 32'h0000_7000, 32'h0);
    n_total++; if (a_resp_valid !== 1'b1) $display("FAIL size3_resp_valid got %0h want 1", a_resp_valid); else n_pass++;
    n_total++; if (a_resp_err !== 1'b1) $display("FAIL size3_resp_err got %0h want 1", a_resp_err); else n_pass++;
    n_total++; if (a_mem_valid !== 1'b0) $display("FAIL size3_mem_valid got %0h want 0", a_mem_valid); else n_pass++;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_size = 2'd2; b_req_addr = 32'h0000_3001;
    @(negedge clk);
    b_req_valid = 1'b0;
    n_total++; if (b_resp_valid !== 1'b1) $display("FAIL mis_resp_valid got %0h want 1", b_resp_valid); else n_pass++;
    n_total++; if (b_resp_err !== 1'b1) $display("FAIL mis_resp_err got %0h want 1", b_resp_err); else n_pass++;
    n_total++; if (b_mem_valid !== 1'b0) $display("FAIL mis_mem_valid got %0h want 0", b_mem_valid); else n_pass++;
    n_total++; if (b_resp_rdata !== 32'h0) $display("FAIL mis_resp_rdata got %0h want 0", b_resp_rdata); else n_pass++;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_addr = 32'h0000_3000;
    @(negedge clk);
    b_req_valid = 1'b0;
    n_total++; if (b_mem_valid !== 1'b1) $display("FAIL aligned_nosplit_valid got %0h want 1", b_mem_valid); else n_pass++;
    b_mem_ready = 1'b1;
    @(negedge clk);
    b_mem_ready = 1'b0; b_mem_rvalid = 1'b1; b_mem_rdata = 32'h1234_5678;
    @(negedge clk);
    b_mem_rvalid = 1'b0;
    n_total++; if (b_resp_rdata !== 32'h1234_5678) $display("FAIL aligned_nosplit_rdata got %0h want 12345678", b_resp_rdata); else n_pass++;
    n_total++; if (b_resp_err !== 1'b0) $display("FAIL aligned_nosplit_err got %0h want 0", b_resp_err); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_lwu64;
    c_req_valid = 1'b1; c_req_size = 2'd2; c_req_unsigned = 1'b1; c_req_addr = 32'h0000_8004;
    @(negedge clk);
    c_req_valid = 1'b0;
    n_total++; if (c_mem_be !== 8'hF0) $display("FAIL lwu64_be got %0h want f0", c_mem_be); else n_pass++;
    n_total++; if (c_mem_addr !== 32'h0000_8000) $display("FAIL lwu64_addr got %0h want 8000", c_mem_addr); else n_pass++;
    c_mem_ready = 1'b1;
    @(negedge clk);
    c_mem_ready = 1'b0; c_mem_rvalid = 1'b1; c_mem_rdata = 64'hFFFF_FFFF_0000_0000;
    @(negedge clk);
    c_mem_rvalid = 1'b0;
    n_total++; if (c_resp_valid !== 1'b1) $display("FAIL lwu64_resp_valid got %0h want 1", c_resp_valid); else n_pass++;
    n_total++; if (c_resp_rdata !== 64'h0000_0000_FFFF_FFFF) $display("FAIL lwu64_rdata got %0h want ffffffff", c_resp_rdata); else n_pass++;
    @(negedge clk);
  endtask

  // Scenario sequence followed by the summary line
  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_split_load();
    test_stall_hold();
    test_reset_mid();
    test_back_to_back();
    test_errors();
    test_lwu64();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
